// File: rtl/ct_f_spsram_init_wrap.sv
// Sliced FPGA single-port SRAM with post-reset fill engine, READY status and sticky access-error flag.
// Optional macro CT_SPSRAM_OUTREG_EN adds an output register on Q (read latency 2).

module fpga_ram #(
  parameter int AW = 9,
  parameter int W  = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] dout_q;

  // Write-first: a written slice returns the new data on the following cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
      dout_q      <= din;
    end else begin
      dout_q      <= mem_q[addr];
    end
  end

  assign dout = dout_q;
endmodule

module ct_f_spsram_init_wrap #(
  parameter int                   ADDR_WIDTH    = 9,
  parameter int                   DATA_WIDTH    = 96,
  parameter int                   WRAP_SIZE     = 24,
  parameter int                   INIT_ON_RESET = 1,
  parameter logic [WRAP_SIZE-1:0] INIT_VALUE    = '0
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  READY,
  output logic                  ACC_ERR
);
  localparam int NSLICE = DATA_WIDTH / WRAP_SIZE;

  if (DATA_WIDTH % WRAP_SIZE != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of WRAP_SIZE");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam state_e ST_RST = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   hold_q, hold_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

  logic                    fill;
  logic                    wr;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [NSLICE-1:0][WRAP_SIZE-1:0] ram_q;
  logic                    unused_wen;

  // Only the top bit of each slice's WEN field is sampled.
  assign unused_wen = ^WEN;

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      hold_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    fill     = 1'b0;
    case (state_q)
      ST_INIT: begin
        fill  = 1'b1;
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (&cnt_q) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN:  ready_d = 1'b1;
      default: state_d = ST_RST;
    endcase
  end

  // Core accesses before READY are dropped but remembered in the sticky flag.
  assign err_d    = err_q | (~ready_q & ~CEN);
  assign hold_d   = CEN ? hold_q : A;
  assign wr       = ready_q & ~CEN & ~GWEN;
  assign ram_addr = fill ? cnt_q : (CEN ? hold_q : A);

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    logic                 we;
    logic [WRAP_SIZE-1:0] din;
    assign we  = fill | (wr & ~WEN[(s+1)*WRAP_SIZE-1]);
    assign din = fill ? INIT_VALUE : D[s*WRAP_SIZE +: WRAP_SIZE];
    fpga_ram #(.AW(ADDR_WIDTH), .W(WRAP_SIZE)) u_ram (
      .clk  (CLK),
      .we   (we),
      .addr (ram_addr),
      .din  (din),
      .dout (ram_q[s])
    );
  end

`ifdef CT_SPSRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] q_q;
  always_ff @(posedge CLK) begin
    if (!RST_B)       q_q <= '0;
    else if (ready_q) q_q <= ram_q;
  end
  assign Q = ready_q ? q_q : '0;
`else
  assign Q = ready_q ? DATA_WIDTH'(ram_q) : '0;
`endif

  assign READY   = ready_q;
  assign ACC_ERR = err_q;
endmodule

// File: tb/tb_ct_f_spsram_init_wrap.sv
// Randomized bench for ct_f_spsram_init_wrap against an array-based memory model.
module tb_ct_f_spsram_init_wrap;
  localparam int AW = 9, DW = 96, WS = 24, NS = DW / WS, DEPTH = 1 << AW;
`ifdef CT_SPSRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK = 1'b0, RST_B = 1'b0, CEN = 1'b1, GWEN = 1'b1;
  logic [AW-1:0] A = '0;
  logic [DW-1:0] WEN = '1, D = '0, Q;
  logic          READY, ACC_ERR;

  int            vec_cnt = 0, err_cnt = 0;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] hold;
  logic [DW-1:0] exp_q [$];

  always #5 CLK = ~CLK;

  ct_f_spsram_init_wrap dut (
    .CLK(CLK), .RST_B(RST_B), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .D(D), .Q(Q), .READY(READY), .ACC_ERR(ACC_ERR)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Model state after a freshly completed fill (INIT_VALUE = 0).
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back('0);
  endtask

  // Apply one edge of the access rules to the model; exp_q[0] is what Q must show now.
  task automatic model_edge();
    logic [AW-1:0] a;
    if (!CEN) begin
      a = A;
      if (!GWEN)
        for (int s = 0; s < NS; s++)
          if (!WEN[(s+1)*WS-1]) mem[a][s*WS +: WS] = D[s*WS +: WS];
      hold = A;
    end else begin
      a = hold;
    end
    exp_q.push_back(mem[a]);
    while (exp_q.size() > LAT) void'(exp_q.pop_front());
  endtask

  task automatic acc(input string tag, input bit cen, input bit gwen, input logic [AW-1:0] a,
                     input logic [DW-1:0] wen, input logic [DW-1:0] d);
    CEN = cen; GWEN = gwen; A = a; WEN = wen; D = d;
    tick();
    model_edge();
    chk(tag, Q, exp_q[0]);
  endtask

  task automatic do_reset();
    RST_B = 1'b0; CEN = 1'b1; GWEN = 1'b1; WEN = '1;
    repeat (4) tick();
    hold = '0;
    chk("rst_ready", DW'(READY), '0);
    chk("rst_q", Q, '0);
    chk("rst_accerr", DW'(ACC_ERR), '0);
  endtask

  // Release reset and count edges until READY; optionally poke an access at init cycle 10.
  task automatic wait_ready(input string tag, input bit poke);
    int n = 0;
    bit qbad = 1'b0;
    RST_B = 1'b1;
    while (!READY && n < 2000) begin
      if (poke && n == 9) begin
        CEN = 1'b0; GWEN = 1'b0; A = 9'h0AA; WEN = '0; D = '1;
      end else begin
        CEN = 1'b1; GWEN = 1'b1; WEN = '1;
      end
      tick();
      n++;
      if (poke && n == 10) begin
        hold = 9'h0AA;
        chk("accerr_set", DW'(ACC_ERR), DW'(1));
      end
      if (Q !== '0) qbad = 1'b1;
    end
    CEN = 1'b1; GWEN = 1'b1; WEN = '1;
    chk({tag, "_latency"}, DW'(n), DW'(512));
    chk({tag, "_q_zero"}, DW'(qbad), '0);
    model_clear();
  endtask

  initial begin
    logic [DW-1:0] pat, exp55, wen_r, d_r;
    bit            c, g;
    logic [AW-1:0] a_r;
    pat   = {12{8'hA5}};
    exp55 = '0;
    exp55[71:48] = pat[71:48];
    wen_r = '1;
    wen_r[71] = 1'b0;

    do_reset();
    wait_ready("init1", 1'b1);
    chk("accerr_hold", DW'(ACC_ERR), DW'(1));

    acc("rd_000", 1'b0, 1'b1, 9'h000, '1, '0);
    acc("rd_1ff", 1'b0, 1'b1, 9'h1FF, '1, '0);
    repeat (LAT - 1) acc("idle", 1'b1, 1'b1, '0, '1, '0);
    chk("rd_1ff_const", Q, '0);
    acc("rd_0aa", 1'b0, 1'b1, 9'h0AA, '1, '0);
    repeat (LAT - 1) acc("idle", 1'b1, 1'b1, '0, '1, '0);
    chk("poke_no_write", Q, '0);

    acc("wr_055", 1'b0, 1'b0, 9'h055, wen_r, pat);
    acc("wr_all_off", 1'b0, 1'b0, 9'h055, '1, ~pat);
    acc("rd_055", 1'b0, 1'b1, 9'h055, '1, '0);
    repeat (LAT - 1) acc("idle", 1'b1, 1'b1, '0, '1, '0);
    chk("wr_055_const", Q, exp55);
    repeat (3) acc("idle_hold", 1'b1, 1'b1, $urandom, '1, '0);
    chk("hold_stable", Q, exp55);

    for (int i = 0; i < 400; i++) begin
      c     = ($urandom_range(0, 3) == 0);
      g     = $urandom_range(0, 1) != 0;
      a_r   = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      wen_r = {$urandom, $urandom, $urandom};
      d_r   = {$urandom, $urandom, $urandom};
      acc("rand", c, g, a_r, wen_r, d_r);
    end
    chk("accerr_sticky", DW'(ACC_ERR), DW'(1));

    do_reset();
    RST_B = 1'b1;
    repeat (300) tick();
    RST_B = 1'b0;
    tick();
    hold = '0;
    chk("midrst_ready", DW'(READY), '0);
    wait_ready("init2", 1'b0);
    chk("accerr_clear", DW'(ACC_ERR), '0);

    acc("rd_055_refill", 1'b0, 1'b1, 9'h055, '1, '0);
    repeat (LAT - 1) acc("idle", 1'b1, 1'b1, '0, '1, '0);
    chk("refill_055", Q, '0);
    for (int i = 0; i < 200; i++) begin
      c     = ($urandom_range(0, 3) == 0);
      g     = $urandom_range(0, 1) != 0;
      a_r   = AW'($urandom_range(0, 7));
      wen_r = {$urandom, $urandom, $urandom};
      d_r   = {$urandom, $urandom, $urandom};
      acc("rand2", c, g, a_r, wen_r, d_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
